custom_axi_accum_engine: RTL and testbench
==========================================

Name: custom_axi_accum_engine

Overview:
- Parametrised successor to the single-shot increment engine. Accepts an operand, start step and iteration count over a valid/ready input handshake, then adds the step to the operand once per cycle for the requested count.
- Returns the result over a valid/ready output handshake with full backpressure.
- Sits behind the register interface of the custom AXI IP; exports its FSM state as the package status_e type.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (>=2).
- STEP_WIDTH, 8, width of per-iteration step (<= DATA_WIDTH); zero-extended before add.
- CNT_WIDTH, 8, width of iteration count; max iterations 2^CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low, clears all state immediately.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  engine can accept; high only in IDLE.
- in_data_i  in  DATA_WIDTH  initial operand.
- in_step_i  in  STEP_WIDTH  increment per iteration.
- in_count_i  in  CNT_WIDTH  number of iterations N.
- out_valid_o  out  1  result valid; high only in DONE.
- out_ready_i  in  1  consumer accepts result.
- out_data_o  out  DATA_WIDTH  result = in_data + N*step mod 2^DATA_WIDTH.
- err_clr_i  in  1  clears sticky ERROR.
- status_o  out  status_e  current FSM state (custom_axi_ip_pkg::IDLE/BUSY/DONE/ERROR).

Behaviour:
- Reset values: in_ready_o=0 while rst_ni low, then 1 (IDLE). out_valid_o=0, out_data_o=0, status_o=IDLE. Internal acc, step, remaining all 0.
- Clock/reset are fixed: single clock clk_i; rst_ni is asynchronous and active-low.
- status_o is driven directly from the state register, with no extra delay.
- IDLE:
  - in_ready_o=1.
  - Accept on in_valid_i && in_ready_o: latch acc=in_data_i, step=in_step_i, remaining=in_count_i.
  - Next state DONE if in_count_i==0, else BUSY.
- BUSY:
  - in_ready_o=0. Each cycle: acc<=acc+zext(step) truncated to DATA_WIDTH; remaining<=remaining-1.
  - When remaining==1, next state is DONE.
- DONE:
  - out_valid_o=1, out_data_o=acc. Both are held stable until out_ready_i is sampled high.
  - Handshake edge: next state IDLE, out_valid_o drops.
- Latency: out_valid_o is high after exactly N rising edges following the accepting edge (N=0 gives valid immediately after the accepting edge). Throughput: one result per N+2 cycles with out_ready_i tied high.
- IDLE is mandatory between transactions; in_ready_o is never high while out_valid_o is high.
- Inputs other than in_valid_i are ignored outside IDLE.
- Illegal state encoding: next state ERROR when the macro is defined, IDLE when it is not. out_valid_o=0 in both cases.
- Reset mid-operation: the transaction is discarded, no output is produced, and the engine returns to IDLE.
- err_clr_i has no effect outside ERROR.

Optional Feature:
- Macro: CUSTOM_AXI_ACCUM_OVF_ERR_EN.
- Defined:
  - Any BUSY add whose carry-out of bit DATA_WIDTH-1 is 1 forces the next state to ERROR, with acc not updated.
  - ERROR: in_ready_o=0, out_valid_o=0, out_data_o holds the last acc.
  - ERROR is left only on a cycle with err_clr_i=1, which returns the engine to IDLE. The result is dropped.
- Not defined: adds wrap modulo 2^DATA_WIDTH silently. ERROR is reachable only via illegal encoding, and status_o never shows ERROR after a legal transaction.

Test Plan:
- Basic: data=0x10, step=1, count=3, out_ready_i=1 -> out_valid_o high 3 edges after accept, out_data_o=0x13, status sequence IDLE,BUSY x3,DONE,IDLE.
- Zero count: data=0xDEADBEEF, step=5, count=0 -> out_valid_o on the cycle after accept, out_data_o=0xDEADBEEF, BUSY never seen.
- Backpressure: data=0, step=2, count=4, out_ready_i low 5 cycles -> out_valid_o=1 and out_data_o=8 stable throughout; in_ready_o=0 until the handshake, then IDLE.
- Overflow, data=0xFFFFFFFE, step=1, count=3:
  - With macro: ERROR after the 2nd BUSY cycle, out_valid_o never high, err_clr_i=1 returns to IDLE.
  - Without macro: out_data_o=0x00000001.
- Reset mid-op: count=200 accepted, rst_ni pulsed low for half a cycle during BUSY -> status_o=IDLE immediately, out_valid_o=0, next request data=7, step=1, count=1 -> 8.
- Back-to-back: two requests with in_valid_i held high -> second accepted exactly one cycle after the first output handshake; no overlap of in_ready_o and out_valid_o.

Source files
------------

// File: rtl/custom_axi_accum_engine_if.sv
// rtl/custom_axi_accum_engine_if.sv - request/result handshake bundle for the accumulate engine
interface custom_axi_accum_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic [STEP_WIDTH-1:0] in_step_i;
    logic [CNT_WIDTH-1:0]  in_count_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  err_clr_i;

    modport master (
        output in_valid_i, in_data_i, in_step_i, in_count_i, out_ready_i, err_clr_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_step_i, in_count_i, out_ready_i, err_clr_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/custom_axi_accum_engine.sv
// rtl/custom_axi_accum_engine.sv - iterative step accumulator; CUSTOM_AXI_ACCUM_OVF_ERR_EN enables overflow-to-ERROR
package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;
endpackage

module custom_axi_accum_engine
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    custom_axi_accum_engine_if.slave   bus,
    output status_e                    status_o
);
    status_e               state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] sum_lo;
`ifdef CUSTOM_AXI_ACCUM_OVF_ERR_EN
    logic                  carry;

    assign {carry, sum_lo} = {1'b0, acc_q} + (DATA_WIDTH + 1)'(step_q);
`else
    assign sum_lo = acc_q + DATA_WIDTH'(step_q);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i && ready_q) begin
                    acc_d   = bus.in_data_i;
                    step_d  = bus.in_step_i;
                    rem_d   = bus.in_count_i;
                    state_d = (bus.in_count_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
`ifdef CUSTOM_AXI_ACCUM_OVF_ERR_EN
                if (carry) begin
                    state_d = ERROR;
                end else begin
                    acc_d = sum_lo;
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
                end
`else
                acc_d = sum_lo;
                rem_d = rem_q - CNT_WIDTH'(1);
                if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
`endif
            end
            DONE: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            ERROR: begin
                if (bus.err_clr_i) state_d = IDLE;
            end
            default: begin
`ifdef CUSTOM_AXI_ACCUM_OVF_ERR_EN
                state_d = ERROR;
`else
                state_d = IDLE;
`endif
            end
        endcase
        // Handshake flags track the next state so they change on the same edge as status_o.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = acc_q;
    assign status_o        = state_q;
endmodule

// File: tb/tb_custom_axi_accum_engine.sv
// tb/tb_custom_axi_accum_engine.sv - scoreboard bench for the accumulate engine
module tb_custom_axi_accum_engine;
    import custom_axi_ip_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc_edge;
        int          n;
    } sb_t;

    logic    clk;
    logic    rst_n;
    status_e status;
    sb_t     sb[$];
    int      n_checks;
    int      n_errors;
    int      cyc;
    int      n_acc;
    int      last_acc_edge;
    int      last_hs_edge;
    logic    prev_valid;

    custom_axi_accum_engine_if #(.DATA_WIDTH(32), .STEP_WIDTH(8), .CNT_WIDTH(8)) bus ();

    custom_axi_accum_engine #(.DATA_WIDTH(32), .STEP_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .status_o (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic sb_t model(input logic [31:0] d, input logic [7:0] s, input logic [7:0] n);
        sb_t         e;
        logic [32:0] sum;
        e.data = d;
        e.err  = 1'b0;
        e.n    = int'(n);
        for (int i = 0; i < int'(n); i++) begin
            sum = {1'b0, e.data} + {25'd0, s};
`ifdef CUSTOM_AXI_ACCUM_OVF_ERR_EN
            if (sum[32]) begin
                e.err = 1'b1;
                break;
            end
`endif
            e.data = sum[31:0];
        end
        return e;
    endfunction

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        sb_t e;
        prev_valid = 1'b0;
        n_acc = 0;
        last_acc_edge = -1;
        last_hs_edge = -1;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("no_overlap", 64'(bus.in_ready_o & bus.out_valid_o), 64'd0);
                if (bus.in_valid_i && bus.in_ready_o) begin
                    e = model(bus.in_data_i, bus.in_step_i, bus.in_count_i);
                    e.acc_edge = cyc + 1;
                    sb.push_back(e);
                    last_acc_edge = cyc + 1;
                    n_acc++;
                end
                if (bus.out_valid_o && !prev_valid && sb.size() > 0)
                    check("latency", 64'(cyc - sb[0].acc_edge), 64'(sb[0].n));
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 64'd0, 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(bus.out_data_o), 64'(e.data));
                        check("out_no_err", 64'(e.err), 64'd0);
                    end
                    last_hs_edge = cyc + 1;
                end
                prev_valid = bus.out_valid_o;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] s, input logic [7:0] n, input bit keep);
        bit ok;
        bus.in_data_i  = d;
        bus.in_step_i  = s;
        bus.in_count_i = n;
        bus.in_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) ok = 1'b1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (status == IDLE) ok = 1'b1;
        end
        if (!ok) check(tag, 64'd0, 64'd1);
    endtask

    initial begin
        status_e seq[4];
        int      acc0;
        bit      ok;
        sb_t     e;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.in_step_i   = '0;
        bus.in_count_i  = '0;
        bus.out_ready_i = 1'b1;
        bus.err_clr_i   = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_out_data", 64'(bus.out_data_o), 64'd0);
        check("rst_status", 64'(status), 64'(IDLE));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Basic: status walk through BUSY x3, DONE, IDLE
        send(32'h10, 8'd1, 8'd3, 1'b0);
        check("basic_busy0", 64'(status), 64'(BUSY));
        seq = '{BUSY, BUSY, DONE, IDLE};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("basic_seq%0d", i), 64'(status), 64'(seq[i]));
            if (seq[i] == DONE) check("basic_data", 64'(bus.out_data_o), 64'h13);
        end

        // Zero count
        send(32'hDEADBEEF, 8'd5, 8'd0, 1'b0);
        check("zero_status", 64'(status), 64'(DONE));
        check("zero_valid", 64'(bus.out_valid_o), 64'd1);
        check("zero_data", 64'(bus.out_data_o), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        check("zero_idle", 64'(status), 64'(IDLE));

        // Backpressure
        bus.out_ready_i = 1'b0;
        send(32'd0, 8'd2, 8'd4, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.out_valid_o), 64'd1);
            check("bp_data", 64'(bus.out_data_o), 64'd8);
            check("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", 64'(status), 64'(IDLE));
        check("bp_in_ready_after", 64'(bus.in_ready_o), 64'd1);

        // Overflow
        send(32'hFFFFFFFE, 8'd1, 8'd3, 1'b0);
`ifdef CUSTOM_AXI_ACCUM_OVF_ERR_EN
        check("ovf_busy0", 64'(status), 64'(BUSY));
        @(posedge clk);
        #1;
        check("ovf_busy1", 64'(status), 64'(BUSY));
        @(posedge clk);
        #1;
        check("ovf_error", 64'(status), 64'(ERROR));
        check("ovf_valid", 64'(bus.out_valid_o), 64'd0);
        check("ovf_hold", 64'(bus.out_data_o), 64'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sticky", 64'(status), 64'(ERROR));
        check("ovf_in_ready", 64'(bus.in_ready_o), 64'd0);
        bus.err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr_i = 1'b0;
        check("ovf_clr_idle", 64'(status), 64'(IDLE));
        if (sb.size() == 0) begin
            check("ovf_sb_entry", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("ovf_model_err", 64'(e.err), 64'd1);
        end
`else
        wait_idle("ovf_timeout");
        check("ovf_wrap_data", 64'(bus.out_data_o), 64'h1);
`endif

        // Reset mid-operation
        send(32'd5, 8'd1, 8'd200, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_status", 64'(status), 64'(IDLE));
        check("rstmid_valid", 64'(bus.out_valid_o), 64'd0);
        check("rstmid_data", 64'(bus.out_data_o), 64'd0);
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_ready", 64'(bus.in_ready_o), 64'd1);
        send(32'd7, 8'd1, 8'd1, 1'b0);
        wait_idle("rstmid_timeout");
        check("rstmid_result", 64'(bus.out_data_o), 64'd8);

        // Back-to-back with in_valid held high
        acc0 = n_acc;
        send(32'd100, 8'd3, 8'd2, 1'b1);
        bus.in_data_i  = 32'd50;
        bus.in_step_i  = 8'd4;
        bus.in_count_i = 8'd1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (n_acc >= acc0 + 2) ok = 1'b1;
        end
        bus.in_valid_i = 1'b0;
        check("b2b_accepted", 64'(ok), 64'd1);
        check("b2b_gap", 64'(last_acc_edge), 64'(last_hs_edge + 1));
        wait_idle("b2b_timeout");
        check("b2b_result", 64'(bus.out_data_o), 64'd54);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
